// File: rtl/led_blink_scheduler.sv
// LED blink rate scheduler: steps a 2-bit rate select through 100/50/10/1 Hz, either on a dwell
// timer or on button presses. Define LED_SCHED_DEBOUNCE_EN to add a button debouncer.
module led_blink_scheduler #(
   parameter int unsigned c_DWELL_CNT    = 25000,
   parameter int unsigned c_DEBOUNCE_CNT = 250
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic       i_hold,
   input  logic       i_mode,
   input  logic       i_button,
   output logic       o_switch_1,
   output logic       o_switch_2,
   output logic       o_enable,
   output logic       o_busy,
   output logic [1:0] o_step
);

   localparam int unsigned c_DW_W = (c_DWELL_CNT > 1) ? $clog2(c_DWELL_CNT) : 1;
   localparam logic [c_DW_W-1:0] c_DW_MAX = c_DW_W'(c_DWELL_CNT - 1);

   typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StPause = 2'd2} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [c_DW_W-1:0] r_dwell;
   logic [c_DW_W-1:0] w_dwell_next;
   logic [1:0]        r_step;
   logic [1:0]        w_step_next;
   logic              r_enable;
   logic              r_busy;
   logic              w_run_next;
   logic              r_mode_prev;
   logic              w_mode_chg;
   logic              w_active;
   logic              w_expire;
   logic              w_man_adv;
   logic              r_btn_meta;
   logic              r_btn_sync;
   logic              w_press;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_btn_meta <= 1'b0;
         r_btn_sync <= 1'b0;
      end else begin
         r_btn_meta <= i_button;
         r_btn_sync <= r_btn_meta;
      end
   end

`ifdef LED_SCHED_DEBOUNCE_EN
   localparam int unsigned c_DB_W = (c_DEBOUNCE_CNT > 1) ? $clog2(c_DEBOUNCE_CNT) : 1;
   localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(c_DEBOUNCE_CNT - 1);

   logic [c_DB_W-1:0] r_deb_cnt;
   logic              r_btn_level;
   logic              w_deb_done;

   assign w_deb_done = (r_btn_sync != r_btn_level) && (r_deb_cnt == c_DB_MAX);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_deb_cnt   <= '0;
         r_btn_level <= 1'b0;
      end else if (r_btn_sync == r_btn_level) begin
         r_deb_cnt <= '0;
      end else if (w_deb_done) begin
         r_deb_cnt   <= '0;
         r_btn_level <= r_btn_sync;
      end else begin
         r_deb_cnt <= r_deb_cnt + 1'b1;
      end
   end

   // Pulse coincides with the edge that accepts the new high level.
   assign w_press = w_deb_done & r_btn_sync;
`else
   logic r_btn_prev;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_btn_prev <= 1'b0;
      end else begin
         r_btn_prev <= r_btn_sync;
      end
   end

   assign w_press = r_btn_sync & ~r_btn_prev;
`endif

   assign w_mode_chg = i_mode ^ r_mode_prev;
   assign w_active   = (r_state != StIdle) && !i_stop && !i_hold;
   assign w_expire   = w_active && !i_mode && !w_mode_chg && (r_dwell == c_DW_MAX);
   assign w_man_adv  = (r_state == StRun) && !i_stop && !i_hold && i_mode && w_press;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_dwell     <= '0;
         r_step      <= 2'd0;
         r_enable    <= 1'b0;
         r_busy      <= 1'b0;
         r_mode_prev <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_dwell     <= w_dwell_next;
         r_step      <= w_step_next;
         r_enable    <= w_run_next;
         r_busy      <= w_run_next;
         r_mode_prev <= i_mode;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (i_start && !i_stop) w_state_next = StRun;
         StRun: begin
            if (i_stop)      w_state_next = StIdle;
            else if (i_hold) w_state_next = StPause;
         end
         StPause: begin
            if (i_stop)       w_state_next = StIdle;
            else if (!i_hold) w_state_next = StRun;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      w_dwell_next = r_dwell;
      w_step_next  = r_step;
      w_run_next   = (w_state_next != StIdle);
      if (w_state_next == StIdle) begin
         w_dwell_next = '0;
         w_step_next  = 2'd0;
      end else begin
         // A held count stays frozen, but a mode change still restarts the dwell.
         if (w_mode_chg) begin
            w_dwell_next = '0;
         end else if (w_active) begin
            w_dwell_next = (i_mode || r_dwell == c_DW_MAX) ? '0 : r_dwell + 1'b1;
         end
         if (w_expire || w_man_adv) begin
            w_step_next = r_step + 2'd1;
         end
      end
   end

   assign o_step     = r_step;
   assign o_switch_1 = r_step[1];
   assign o_switch_2 = r_step[0];
   assign o_enable   = r_enable;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler: a vector table for the IDLE/RUN/PAUSE control plus
// hand sequences for auto stepping, hold, button handling and asynchronous reset.
module tb_led_blink_scheduler;

   localparam int unsigned c_DW = 8;
   localparam int unsigned c_DB = 4;
`ifdef LED_SCHED_DEBOUNCE_EN
   localparam int c_LAT = 2 + c_DB;
   localparam bit c_DEB = 1'b1;
`else
   localparam int c_LAT = 3;
   localparam bit c_DEB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, start, stop, hold, mode, button;
   logic       sw1, sw2, en, busy;
   logic [1:0] step;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [1:0] exp_man;

   typedef struct packed {
      logic       start;
      logic       stop;
      logic       hold;
      logic       exp_en;
      logic       exp_busy;
      logic [1:0] exp_step;
   } vec_t;

   vec_t vecs [8];

   led_blink_scheduler #(
      .c_DWELL_CNT   (c_DW),
      .c_DEBOUNCE_CNT(c_DB)
   ) dut (
      .i_clock   (clk),
      .i_reset   (rst),
      .i_start   (start),
      .i_stop    (stop),
      .i_hold    (hold),
      .i_mode    (mode),
      .i_button  (button),
      .o_switch_1(sw1),
      .o_switch_2(sw2),
      .o_enable  (en),
      .o_busy    (busy),
      .o_step    (step)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic e_en, input logic e_busy,
                             input logic [1:0] e_step);
      check({name, ".enable"}, {7'd0, en}, {7'd0, e_en});
      check({name, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
      check({name, ".step"}, {6'd0, step}, {6'd0, e_step});
      check({name, ".switch"}, {6'd0, sw1, sw2}, {6'd0, e_step});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0; button = 1'b0;
      #1;
      check_outs("reset", 1'b0, 1'b0, 2'd0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // start stop hold | en busy step
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};

      do_reset();
      for (int i = 0; i < 8; i++) begin
         start = vecs[i].start;
         stop  = vecs[i].stop;
         hold  = vecs[i].hold;
         tick();
         check_outs($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_busy, vecs[i].exp_step);
      end

      // Auto stepping with wrap
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_outs("auto_start", 1'b1, 1'b1, 2'd0);
      for (int k = 1; k <= 32; k++) begin
         tick();
         check_outs($sformatf("auto_k%0d", k), 1'b1, 1'b1, 2'((k / 8) % 4));
      end

      // Reset between edges, then restart
      #3;
      rst = 1'b1;
      #1;
      check_outs("rst_async", 1'b0, 1'b0, 2'd0);
      #2;
      rst = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_outs("restart", 1'b1, 1'b1, 2'd0);
      repeat (7) tick();
      check_outs("restart_pre", 1'b1, 1'b1, 2'd0);
      tick();
      check_outs("restart_adv", 1'b1, 1'b1, 2'd1);

      // Hold at count 5 for 20 cycles
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      hold = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         check_outs($sformatf("hold_c%0d", k), 1'b1, 1'b1, 2'd0);
      end
      hold = 1'b0;
      tick();
      tick();
      check_outs("hold_pre", 1'b1, 1'b1, 2'd0);
      tick();
      check_outs("hold_adv", 1'b1, 1'b1, 2'd1);

      // Manual mode: one 6-cycle press, then a 2-cycle glitch
      do_reset();
      mode  = 1'b1;
      start = 1'b1;
      tick();
      start  = 1'b0;
      button = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         check_outs($sformatf("man_e%0d", e), 1'b1, 1'b1, (e >= c_LAT) ? 2'd1 : 2'd0);
      end
      button = 1'b0;
      repeat (10) tick();
      check_outs("man_single", 1'b1, 1'b1, 2'd1);
      button = 1'b1;
      tick();
      tick();
      button = 1'b0;
      repeat (12) tick();
      exp_man = c_DEB ? 2'd1 : 2'd2;
      check_outs("man_glitch", 1'b1, 1'b1, exp_man);

      // Presses during PAUSE are discarded
      hold = 1'b1;
      tick();
      button = 1'b1;
      repeat (6) tick();
      button = 1'b0;
      repeat (8) tick();
      check_outs("pause_hold", 1'b1, 1'b1, exp_man);
      hold = 1'b0;
      repeat (3) tick();
      check_outs("pause_discard", 1'b1, 1'b1, exp_man);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
